countdown_sequencer: RTL and testbench

//  Initiator side of the loadable down-counter interface. Queues count requests
//  (valid/ready) and drives load/data to one 4-bit down counter, one request at a time.
//  It waits for the counter's done, then reports completion. It sits between a

---
 rtl/countdown_sequencer.sv | 139 +++++++++++++
 tb/tb_countdown_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_sequencer.sv
// Request queue and sequencer for a loadable down counter: pops one queued count at a time,
// loads it, waits for the counter to reach zero, and reports completion or timeout.
module countdown_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 18
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  input  logic [WIDTH-1:0] i_req_data,
  output logic             o_req_ready,
  output logic             o_cnt_load,
  output logic [WIDTH-1:0] o_cnt_data,
  input  logic [WIDTH-1:0] i_cnt_value,
  input  logic             i_cnt_done,
  output logic             o_busy,
  output logic             o_cmpl_pulse,
  output logic [7:0]       o_cmpl_count,
  output logic             o_timeout_err,
  input  logic             i_clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FullCnt   = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] WaitLimit = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StArm, StWait, StDone} state_e;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  state_e           r_state;
  logic [TW-1:0]    r_wait_cnt;
  logic             r_cnt_load;
  logic [WIDTH-1:0] r_cnt_data;
  logic             r_cmpl_pulse;
  logic [7:0]       r_cmpl_count;
  logic             r_timeout_err;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_hit;
  logic w_expire;

  assign w_full   = (r_count == FullCnt);
  assign w_empty  = (r_count == '0);
  // Full is judged on registered occupancy, so a same-cycle pop never frees a slot.
  assign w_push   = i_req_valid && !w_full;
  assign w_pop    = (r_state == StIdle) && !w_empty;
  assign w_hit    = i_cnt_done && (i_cnt_value == '0);
  assign w_expire = (r_wait_cnt == WaitLimit);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_req_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_wait_cnt    <= '0;
      r_cnt_load    <= 1'b0;
      r_cnt_data    <= '0;
      r_cmpl_pulse  <= 1'b0;
      r_cmpl_count  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cnt_load   <= 1'b0;
      r_cmpl_pulse <= 1'b0;
      if (i_clr_err) begin
        r_timeout_err <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_cnt_data <= r_mem[r_rd_ptr];
            r_cnt_load <= 1'b1;
            r_state    <= StLoad;
          end
        end
        StLoad: r_state <= StArm;
        StArm: begin
          r_wait_cnt <= '0;
          r_state    <= StWait;
        end
        StWait: begin
          if (w_hit) begin
            r_cmpl_pulse <= 1'b1;
            r_cmpl_count <= r_cmpl_count + 8'd1;
            r_state      <= StDone;
          end else if (w_expire) begin
            // Written after the clear above so a coincident set wins.
            r_timeout_err <= 1'b1;
            r_state       <= StIdle;
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready   = !w_full;
  assign o_busy        = !w_empty || (r_state != StIdle);
  assign o_cnt_load    = r_cnt_load;
  assign o_cnt_data    = r_cnt_data;
  assign o_cmpl_pulse  = r_cmpl_pulse;
  assign o_cmpl_count  = r_cmpl_count;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: behavioural down counter, queue-based request model,
// directed scenarios plus a randomized request stream.
module tb_countdown_sequencer;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_data = '0;
  logic       req_ready;
  logic       cnt_load;
  logic [3:0] cnt_data;
  logic [3:0] cnt_value = '0;
  logic       cnt_done;
  logic       busy;
  logic       cmpl_pulse;
  logic [7:0] cmpl_count;
  logic       timeout_err;
  logic       clr_err = 1'b0;

  logic       hold = 1'b0;
  logic       mon_en = 1'b0;
  logic [3:0] model_q [$];
  logic [7:0] exp_cmpl = '0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_load = 0;
  int         n_pulse = 0;
  int         cyc = 0;
  int         last_push_cyc = 0;
  int         last_load_cyc = 0;
  logic       prev_load = 1'b0;
  logic       prev_pulse = 1'b0;

  countdown_sequencer #(.WIDTH(4), .DEPTH(Depth), .TIMEOUT(18)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .o_cnt_load   (cnt_load),
    .o_cnt_data   (cnt_data),
    .i_cnt_value  (cnt_value),
    .i_cnt_done   (cnt_done),
    .o_busy       (busy),
    .o_cmpl_pulse (cmpl_pulse),
    .o_cmpl_count (cmpl_count),
    .o_timeout_err(timeout_err),
    .i_clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  // Behavioural down counter; hold suppresses done to force a timeout.
  always @(posedge clk) begin
    if (cnt_load) cnt_value <= cnt_data;
    else if (cnt_value != 0) cnt_value <= cnt_value - 4'd1;
  end
  assign cnt_done = (cnt_value == 4'd0) && !hold;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: accepted requests queue up and must load in arrival order.
  always begin
    logic pushed;
    @(posedge clk);
    cyc++;
    pushed = mon_en && rst_n && req_valid && req_ready;
    if (pushed) begin
      model_q.push_back(req_data);
      last_push_cyc = cyc;
    end
    #1;
    if (mon_en && rst_n) begin
      if (cnt_load) begin
        n_load++;
        last_load_cyc = cyc;
        check_eq("load_1cyc", 32'(prev_load), 0);
        if (model_q.size() == 0) check_eq("load_unexp", 32'(cnt_load), 0);
        else check_eq("load_data", 32'(cnt_data), 32'(model_q.pop_front()));
      end
      if (cmpl_pulse) begin
        n_pulse++;
        exp_cmpl = exp_cmpl + 8'd1;
        check_eq("pulse_1cyc", 32'(prev_pulse), 0);
        check_eq("cmpl_count", 32'(cmpl_count), 32'(exp_cmpl));
      end
      check_eq("req_ready", 32'(req_ready), 32'(model_q.size() < Depth));
    end
    prev_load  = cnt_load;
    prev_pulse = cmpl_pulse;
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    clr_err = 1'b0;
    #1;
    check_eq("rst_load", 32'(cnt_load), 0);
    check_eq("rst_data", 32'(cnt_data), 0);
    check_eq("rst_pulse", 32'(cmpl_pulse), 0);
    check_eq("rst_count", 32'(cmpl_count), 0);
    check_eq("rst_err", 32'(timeout_err), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_ready", 32'(req_ready), 1);
    model_q.delete();
    exp_cmpl = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Leaves valid high after acceptance so consecutive calls push back-to-back.
  task automatic push(input logic [3:0] v, output int held);
    held = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_data = v;
    while (!req_ready && held < 100) begin
      @(negedge clk);
      held++;
    end
    if (!req_ready) begin
      check_eq("push_to", 32'(req_ready), 1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_to", 32'(busy), 0);
  endtask

  initial begin
    int held;
    int p0;
    int l0;
    int n;
    do_reset();

    // Reset during WAIT with two requests queued.
    push(4'd15, held);
    push(4'd5, held);
    push(4'd6, held);
    drop_valid();
    repeat (4) @(posedge clk);
    do_reset();
    p0 = n_pulse;
    l0 = n_load;
    repeat (30) @(posedge clk);
    check_eq("rst_no_pulse", 32'(n_pulse - p0), 0);
    check_eq("rst_no_load", 32'(n_load - l0), 0);

    // Single request of 3.
    p0 = n_pulse;
    l0 = n_load;
    push(4'd3, held);
    drop_valid();
    wait_idle(100);
    check_eq("s_loads", 32'(n_load - l0), 1);
    check_eq("s_pulses", 32'(n_pulse - p0), 1);
    check_eq("s_latency", 32'(last_load_cyc - last_push_cyc), 1);
    check_eq("s_count", 32'(cmpl_count), 1);
    check_eq("s_data_hold", 32'(cnt_data), 3);

    // Burst: one in flight, FIFO fills, last push is held until a slot frees.
    do_reset();
    p0 = n_pulse;
    push(4'd15, held);
    push(4'd1, held);
    push(4'd2, held);
    push(4'd0, held);
    push(4'd5, held);
    check_eq("b_not_held", 32'(held), 0);
    push(4'd9, held);
    check_eq("b_held", 32'(held > 0), 1);
    drop_valid();
    wait_idle(300);
    check_eq("b_pulses", 32'(n_pulse - p0), 6);
    check_eq("b_count", 32'(cmpl_count), 6);
    check_eq("b_q_empty", 32'(model_q.size()), 0);

    // Zero-valued request.
    p0 = n_pulse;
    push(4'd0, held);
    drop_valid();
    wait_idle(100);
    check_eq("z_pulses", 32'(n_pulse - p0), 1);
    check_eq("z_err", 32'(timeout_err), 0);
    check_eq("z_count", 32'(cmpl_count), 7);

    // Timeout with done suppressed, then recovery and clear.
    hold = 1'b1;
    p0 = n_pulse;
    push(4'd4, held);
    drop_valid();
    n = 0;
    while (!timeout_err && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq("t_err", 32'(timeout_err), 1);
    check_eq("t_latency", 32'(cyc - last_load_cyc), 20);
    check_eq("t_busy", 32'(busy), 0);
    check_eq("t_no_pulse", 32'(n_pulse - p0), 0);
    hold = 1'b0;
    push(4'd2, held);
    drop_valid();
    wait_idle(100);
    check_eq("t_next_pulse", 32'(n_pulse - p0), 1);
    check_eq("t_sticky", 32'(timeout_err), 1);
    check_eq("t_count", 32'(cmpl_count), 8);
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #2;
    check_eq("t_clr", 32'(timeout_err), 0);
    @(negedge clk);
    clr_err = 1'b0;

    // 256 requests of 1: completion counter wraps.
    do_reset();
    p0 = n_pulse;
    for (int i = 0; i < 256; i++) push(4'd1, held);
    drop_valid();
    wait_idle(100);
    check_eq("w_pulses", 32'(n_pulse - p0), 256);
    check_eq("w_count", 32'(cmpl_count), 0);

    // Randomized request stream with random gaps.
    do_reset();
    p0 = n_pulse;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        drop_valid();
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      push(4'($urandom_range(0, 15)), held);
    end
    drop_valid();
    wait_idle(300);
    check_eq("r_pulses", 32'(n_pulse - p0), 40);
    check_eq("r_count", 32'(cmpl_count), 40);
    check_eq("r_err", 32'(timeout_err), 0);
    check_eq("r_q_empty", 32'(model_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
